multiplier_iterative: RTL and testbench

Unsigned 32×32→64-bit sequential multiplier that computes one shift-add step per clock. The block serves as a low-area functional unit for datapaths that can tolerate a fixed multi-cycle latency. A one-cycle `valid_in` pulse starts an operation, and `valid_out` pulses when the product on `r` is ready.

---
 rtl/multiplier_iterative.sv | 154 +++++++++++++++
 tb/tb_multiplier_iterative.sv | 361 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier_iterative.sv
// -----------------------------------------------------------------------------
// multiplier_iterative
//
// Unsigned 32x32 -> 64-bit sequential shift-add multiplier. One partial
// product is folded into the accumulator per clock, so a product takes a
// fixed 32 cycles from the accepting edge to the result pulse.
//
// Ports:
//   clk       in   1   single clock, rising edge
//   reset     in   1   asynchronous, active-high reset
//   valid_in  in   1   start strobe, sampled on rising clk
//   a         in  32   unsigned multiplicand, captured on the accepting edge
//   b         in  32   unsigned multiplier, captured on the accepting edge
//   valid_out out  1   one-cycle pulse marking r as a new product
//   r         out 64   registered product, held until the next completion
//
// Handshake: there is no ready signal. A start is accepted on any rising
// edge where valid_in=1 and the block is IDLE or DONE; while BUSY, valid_in
// is ignored and the operands are not re-sampled. valid_out is high for
// exactly one cycle (the DONE state) per accepted operation, and r only
// changes on that completion edge (or on reset).
// -----------------------------------------------------------------------------
module multiplier_iterative (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_in,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        valid_out,
  output logic [63:0] r
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // FSM state, kept as a named signal so checkers can bind to it.
  state_t state;
  state_t state_next;

  // Datapath registers.
  logic [63:0] mcand;   // multiplicand, shifted left one place per step
  logic [31:0] mplier;  // multiplier, shifted right one place per step
  logic [63:0] acc;     // running partial-product sum
  logic [4:0]  count;   // completed BUSY steps, 0..31

  // Control decoded from the current state.
  logic load;           // accept a new start on this edge
  logic step;           // perform one shift-add step on this edge
  logic finish;         // this edge is the 32nd step

  // Next accumulator value for the current step. The sum of at most 32
  // shifted copies of a 32-bit operand always fits in 64 bits.
  logic [63:0] acc_sum;

  assign acc_sum = mplier[0] ? (acc + mcand) : acc;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and control decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    finish     = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (valid_in) begin
          load       = 1'b1;
          state_next = S_BUSY;
        end
      end

      S_BUSY: begin
        step = 1'b1;
        if (count == 5'd31) begin
          finish     = 1'b1;
          state_next = S_DONE;
        end
      end

      S_DONE: begin
        // A start on the edge leaving DONE is accepted just as from IDLE,
        // giving back-to-back operations a 33-cycle throughput.
        if (valid_in) begin
          load       = 1'b1;
          state_next = S_BUSY;
        end else begin
          state_next = S_IDLE;
        end
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Shift-add datapath
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand  <= 64'd0;
      mplier <= 32'd0;
      acc    <= 64'd0;
      count  <= 5'd0;
    end else if (load) begin
      mcand  <= {32'd0, a};
      mplier <= b;
      acc    <= 64'd0;
      count  <= 5'd0;
    end else if (step) begin
      acc    <= acc_sum;
      mcand  <= {mcand[62:0], 1'b0};
      mplier <= {1'b0, mplier[31:1]};
      // Wraps to 0 after the last step; it is reloaded on the next start.
      count  <= count + 5'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Output registers
  // ---------------------------------------------------------------------------
  // valid_out is high only in the cycle after the finishing edge, i.e. while
  // the FSM sits in DONE. r captures the sum including the final step's
  // addition and otherwise holds its value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_out <= 1'b0;
      r         <= 64'd0;
    end else begin
      valid_out <= finish;
      if (finish) begin
        r <= acc_sum;
      end
    end
  end

endmodule

// File: tb/tb_multiplier_iterative.sv
// -----------------------------------------------------------------------------
// tb_multiplier_iterative
//
// Self-checking bench for multiplier_iterative. Expected products come from a
// plain 64-bit arithmetic reference model and travel through exp_q.
// -----------------------------------------------------------------------------
module tb_multiplier_iterative;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic [63:0] r;

  always #5 clk = ~clk;

  multiplier_iterative dut (
    .clk       (clk),
    .reset     (reset),
    .valid_in  (valid_in),
    .a         (a),
    .b         (b),
    .valid_out (valid_out),
    .r         (r)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------------
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];

  // Reference model: exact unsigned product.
  function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx;
    logic [63:0] yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks (no checking inside)
  // ---------------------------------------------------------------------------
  // Presents a one-cycle start pulse. Returns at the falling edge just after
  // the accepting edge, with the operands scrambled so that any late
  // re-sampling would corrupt the product.
  task automatic start_op(input logic [31:0] x, input logic [31:0] y);
    @(negedge clk);
    valid_in = 1'b1;
    a        = x;
    b        = y;
    @(negedge clk);
    valid_in = 1'b0;
    a        = $urandom;
    b        = $urandom;
  endtask

  // Waits (bounded) for valid_out. lat counts rising edges after the accepting
  // edge; 0 means no pulse within the bound. stable reports whether r held
  // its pre-start value until the pulse; vo_after is valid_out one cycle later.
  task automatic wait_done(input logic [63:0] r_before, output int lat,
                           output logic [63:0] res, output logic stable,
                           output logic vo_after);
    lat    = 0;
    stable = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
      if (r !== r_before) stable = 1'b0;
    end
    res = r;
    @(negedge clk);
    vo_after = valid_out;
  endtask

  task automatic do_op(input logic [31:0] x, input logic [31:0] y, output int lat,
                       output logic [63:0] res, output logic stable,
                       output logic vo_after);
    logic [63:0] r_before;
    r_before = r;
    start_op(x, y);
    wait_done(r_before, lat, res, stable, vo_after);
  endtask

  // ---------------------------------------------------------------------------
  // Tests
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset    = 1'b1;
    valid_in = 1'b0;
    a        = 32'd0;
    b        = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (valid_out !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid_out: got %b expected 0", valid_out);
    end
    checks++;
    if (r !== 64'd0) begin
      errors++;
      $display("FAIL reset_r: got %h expected 0", r);
    end
    reset = 1'b0;
  endtask

  task automatic test_zero();
    int lat;
    logic [63:0] res;
    logic stable, vo_after;
    do_op(32'd0, 32'd0, lat, res, stable, vo_after);
    checks++;
    if (lat !== 32) begin
      errors++;
      $display("FAIL zero_latency: got %0d expected 32", lat);
    end
    checks++;
    if (res !== 64'd0) begin
      errors++;
      $display("FAIL zero_r: got %h expected 0", res);
    end
    checks++;
    if (vo_after !== 1'b0) begin
      errors++;
      $display("FAIL zero_pulse_width: got %b expected 0", vo_after);
    end
  endtask

  // Runs a list of operand pairs, checking product, latency and r stability.
  task automatic run_list(input string name, input logic [31:0] xs[$], input logic [31:0] ys[$]);
    int lat;
    logic [63:0] res, exp;
    logic stable, vo_after;
    for (int i = 0; i < xs.size(); i++) begin
      exp_q.push_back(ref_mul(xs[i], ys[i]));
      do_op(xs[i], ys[i], lat, res, stable, vo_after);
      exp = exp_q.pop_front();
      checks++;
      if (res !== exp || lat !== 32 || stable !== 1'b1 || vo_after !== 1'b0) begin
        errors++;
        $display("FAIL %s[%0d]: a=%h b=%h got r=%h lat=%0d stable=%b vo_after=%b expected r=%h lat=32 stable=1 vo_after=0",
                 name, i, xs[i], ys[i], res, lat, stable, vo_after, exp);
      end
    end
  endtask

  task automatic test_small();
    logic [31:0] xs[$];
    logic [31:0] ys[$];
    xs = '{32'd5, 32'd1};
    ys = '{32'd7, 32'hFFFF_FFFF};
    run_list("small", xs, ys);
  endtask

  task automatic test_max();
    int lat;
    logic [63:0] res;
    logic stable, vo_after;
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, res, stable, vo_after);
    checks++;
    if (res !== 64'hFFFF_FFFE_0000_0001 || lat !== 32) begin
      errors++;
      $display("FAIL max_r: got r=%h lat=%0d expected r=fffffffe00000001 lat=32", res, lat);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] xs[$];
    logic [31:0] ys[$];
    logic [31:0] x, y;
    for (int k = 0; k < 100; k++) begin
      xs.push_back(32'(k));
      ys.push_back(32'(k));
    end
    run_list("square", xs, ys);
    xs.delete();
    ys.delete();
    x = 32'd0;
    y = 32'd0;
    for (int k = 0; k < 100; k++) begin
      x = x + 32'h2345_6789;
      y = y + 32'h3456_7891;
      xs.push_back(x);
      ys.push_back(y);
    end
    run_list("step", xs, ys);
  endtask

  task automatic test_random();
    logic [31:0] xs[$];
    logic [31:0] ys[$];
    for (int k = 0; k < 20; k++) begin
      xs.push_back($urandom);
      ys.push_back($urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 255)) : $urandom);
    end
    run_list("random", xs, ys);
  endtask

  // A second start during BUSY must be ignored.
  task automatic test_busy();
    int lat, pulses;
    logic [63:0] res;
    logic r_changed;
    lat = 0;
    start_op(32'd3, 32'd4);
    repeat (8) @(negedge clk);
    valid_in = 1'b1;
    a        = 32'd9;
    b        = 32'd9;
    @(negedge clk);
    valid_in = 1'b0;
    // Now just after edge N+9.
    for (int i = 10; i <= 40; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
    end
    res = r;
    checks++;
    if (lat !== 32 || res !== 64'd12) begin
      errors++;
      $display("FAIL busy_result: got r=%h lat=%0d expected r=c lat=32", res, lat);
    end
    pulses    = 0;
    r_changed = 1'b0;
    @(negedge clk);
    repeat (40) begin
      @(negedge clk);
      if (valid_out === 1'b1) pulses++;
      if (r !== 64'd12) r_changed = 1'b1;
    end
    checks++;
    if (pulses !== 0 || r_changed !== 1'b0) begin
      errors++;
      $display("FAIL busy_extra: got pulses=%0d r_changed=%b expected pulses=0 r_changed=0", pulses, r_changed);
    end
  endtask

  // Start accepted on the edge leaving DONE.
  task automatic test_back_to_back();
    int lat;
    logic [63:0] first_r, exp1, exp2;
    logic [31:0] x1, y1, x2, y2;
    x1 = $urandom;
    y1 = $urandom;
    x2 = $urandom;
    y2 = $urandom;
    exp_q.push_back(ref_mul(x1, y1));
    exp_q.push_back(ref_mul(x2, y2));
    start_op(x1, y1);
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
    end
    first_r = r;
    // In DONE: request the next operation.
    valid_in = 1'b1;
    a        = x2;
    b        = y2;
    @(negedge clk);
    valid_in = 1'b0;
    a        = $urandom;
    b        = $urandom;
    exp1 = exp_q.pop_front();
    checks++;
    if (lat !== 32 || first_r !== exp1 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL b2b_first: got r=%h lat=%0d vo_after=%b expected r=%h lat=32 vo_after=0",
               first_r, lat, valid_out, exp1);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (valid_out === 1'b1) begin
        lat = i;
        break;
      end
    end
    exp2 = exp_q.pop_front();
    checks++;
    if (lat !== 32 || r !== exp2) begin
      errors++;
      $display("FAIL b2b_second: got r=%h lat=%0d expected r=%h lat=32", r, lat, exp2);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat, pulses;
    logic [63:0] res;
    logic stable, vo_after;
    start_op(32'd6, 32'd7);
    repeat (14) @(negedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (valid_out !== 1'b0 || r !== 64'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got valid_out=%b r=%h expected valid_out=0 r=0", valid_out, r);
    end
    // valid_in together with reset must not start anything.
    @(negedge clk);
    valid_in = 1'b1;
    a        = 32'd6;
    b        = 32'd7;
    @(negedge clk);
    reset    = 1'b0;
    valid_in = 1'b0;
    pulses   = 0;
    repeat (40) begin
      @(negedge clk);
      if (valid_out === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      errors++;
      $display("FAIL reset_mid_abandon: got pulses=%0d expected 0", pulses);
    end
    do_op(32'd6, 32'd7, lat, res, stable, vo_after);
    checks++;
    if (lat !== 32 || res !== 64'd42) begin
      errors++;
      $display("FAIL reset_mid_restart: got r=%h lat=%0d expected r=2a lat=32", res, lat);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_zero();
    test_small();
    test_max();
    test_sweep();
    test_random();
    test_busy();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
